// File: rtl/target_io_pkg.sv
// Purpose: shared register addresses, mode/power-state encodings and helpers for target_io_ctrl.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package target_io_pkg;

  // Default register-bus addresses owned by the controller.
  localparam logic [5:0] ADDR_IOMODE_DEF  = 6'd52;
  localparam logic [5:0] ADDR_IOSTATE_DEF = 6'd53;
  localparam logic [5:0] ADDR_POWER_DEF   = 6'd54;
  localparam logic [5:0] ADDR_PULSE_DEF   = 6'd55;

  // Register lengths in bytes for fixed-size registers.
  localparam logic [15:0] POWER_LEN = 16'd1;
  localparam logic [15:0] PULSE_LEN = 16'd3;

  // Byte index of the pulse "go" strobe inside the pulse register.
  localparam logic [15:0] PULSE_GO_BYTE = 16'd2;

  // Per-channel pin mode, 2 bits each.
  typedef enum logic [1:0] {
    IOM_HIGHZ = 2'd0,
    IOM_GPIO  = 2'd1,
    IOM_ALT   = 2'd2,
    IOM_PULSE = 2'd3
  } io_mode_e;

  // Target power sequencer state; the encoding is visible in the POWER readback.
  typedef enum logic [1:0] {
    PWR_OFF    = 2'd0,
    PWR_RAMPUP = 2'd1,
    PWR_ON     = 2'd2,
    PWR_DRAIN  = 2'd3
  } pwr_state_e;

  // Width of a down-counter that must hold values 0 .. max_cyc-1.
  function automatic int cnt_width(input int max_cyc);
    return (max_cyc > 2) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/target_pwr_seq.sv
// Purpose: target power sequencer; ramps power before pins may drive and drains pins before power off.
// Latency: state follows power_req one clock later; ON after SETTLE_CYC cycles of RAMP_UP, OFF after DRAIN_CYC of DRAIN.
// Backpressure: none; power_req is a level, re-assertion during DRAIN waits until OFF.
//
// Ports:
//   clk, reset_i     clock and synchronous active-high reset
//   power_req        requested target power (level)
//   state            current sequencer state
//   target_npower    1 = target supply off
//   pwr_ready        1 only in ON
//   drive_allow      pins may be driven (ON only); gates all pad outputs
module target_pwr_seq
  import target_io_pkg::*;
#(
  parameter int SETTLE_CYC = 1024,
  parameter int DRAIN_CYC  = 256
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       power_req,
  output pwr_state_e state,
  output logic       target_npower,
  output logic       pwr_ready,
  output logic       drive_allow
);

  localparam int CNT_MAX = (SETTLE_CYC > DRAIN_CYC) ? SETTLE_CYC : DRAIN_CYC;
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYC - 1);

  pwr_state_e       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= PWR_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter is loaded on entry to a timed state and
  // counted down to 0, so a load of N-1 gives exactly N cycles in that state.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      PWR_OFF: begin
        if (power_req) begin
          state_nxt = PWR_RAMPUP;
          cnt_nxt   = SETTLE_LOAD;
        end
      end
      PWR_RAMPUP: begin
        if (!power_req) begin
          state_nxt = PWR_DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end else if (cnt_q == '0) begin
          state_nxt = PWR_ON;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      PWR_ON: begin
        if (!power_req) begin
          state_nxt = PWR_DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end
      end
      PWR_DRAIN: begin
        // A returning power_req is deliberately ignored until OFF, so every
        // power cycle completes its full drain time.
        if (cnt_q == '0) begin
          state_nxt = PWR_OFF;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = PWR_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded straight from the state register so the supply and
  // the pin gating change on the same edge the state does.
  always_comb begin
    state         = state_q;
    target_npower = (state_q == PWR_OFF);
    pwr_ready     = (state_q == PWR_ON);
    drive_allow   = (state_q == PWR_ON);
  end

endmodule

// File: rtl/target_io_ctrl.sv
// Purpose: per-channel target pin controller (high-Z / GPIO / alternate / pulse) with power sequencing.
// Latency: register writes act on the next clock; reads return one clock after the strobe; pad mux is combinational.
// Backpressure: none; the register bus is always accepted and unowned/out-of-range accesses are dropped.
//
// Ports:
//   clk, reset_i                     clock and synchronous active-high reset
//   reg_*                            8-bit register bus (reg_datao is 0 when not addressed, for OR-combining)
//   reg_hypaddress / reg_hyplen      combinational register-length query
//   io_in / io_sync                  raw pad inputs and their 2-FF synchronised copy
//   alt_out / alt_oe                 alternate-function drive from other blocks
//   io_out / io_oe                   pad output data and enable (1 = drive)
//   target_npower / pwr_ready        target supply control and ready flag
module target_io_ctrl
  import target_io_pkg::*;
#(
  parameter int         NUM_IO       = 8,
  parameter logic [5:0] ADDR_IOMODE  = ADDR_IOMODE_DEF,
  parameter logic [5:0] ADDR_IOSTATE = ADDR_IOSTATE_DEF,
  parameter logic [5:0] ADDR_POWER   = ADDR_POWER_DEF,
  parameter logic [5:0] ADDR_PULSE   = ADDR_PULSE_DEF,
  parameter int         SETTLE_CYC   = 1024,
  parameter int         DRAIN_CYC    = 256
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic [5:0]        reg_address,
  input  logic [15:0]       reg_bytecnt,
  input  logic [7:0]        reg_datai,
  output logic [7:0]        reg_datao,
  input  logic [15:0]       reg_size,
  input  logic              reg_read,
  input  logic              reg_write,
  input  logic              reg_addrvalid,
  input  logic [5:0]        reg_hypaddress,
  output logic [15:0]       reg_hyplen,
  input  logic [NUM_IO-1:0] io_in,
  input  logic [NUM_IO-1:0] alt_out,
  input  logic [NUM_IO-1:0] alt_oe,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oe,
  output logic [NUM_IO-1:0] io_sync,
  output logic              target_npower,
  output logic              pwr_ready
);

  localparam logic [15:0] IO_LEN = 16'(NUM_IO);

  // Transfer size carries no information for fixed-length registers.
  logic unused_reg_size;
  assign unused_reg_size = ^reg_size;

  io_mode_e [NUM_IO-1:0] mode_q;
  logic     [NUM_IO-1:0] gpio_q;
  logic     [15:0]       width_q;
  logic     [15:0]       pulse_cnt_q;
  logic                  power_req_q;
  logic     [NUM_IO-1:0] sync1_q, sync2_q;

  pwr_state_e pwr_state;
  logic       drive_allow;
  logic       pulse_active;

  logic       wr_en, rd_en;
  logic       wr_iomode, wr_iostate, wr_power, wr_pulse, pulse_go;
  logic [7:0] rd_data;

  logic [NUM_IO-1:0] oe_raw, out_raw;

  // ---------------------------------------------------------------------------
  // Power sequencer
  // ---------------------------------------------------------------------------
  target_pwr_seq #(
    .SETTLE_CYC (SETTLE_CYC),
    .DRAIN_CYC  (DRAIN_CYC)
  ) u_pwr_seq (
    .clk           (clk),
    .reset_i       (reset_i),
    .power_req     (power_req_q),
    .state         (pwr_state),
    .target_npower (target_npower),
    .pwr_ready     (pwr_ready),
    .drive_allow   (drive_allow)
  );

  // ---------------------------------------------------------------------------
  // Register writes
  // ---------------------------------------------------------------------------
  assign wr_en      = reg_write & reg_addrvalid;
  assign rd_en      = reg_read & reg_addrvalid;
  assign wr_iomode  = wr_en & (reg_address == ADDR_IOMODE);
  assign wr_iostate = wr_en & (reg_address == ADDR_IOSTATE);
  assign wr_power   = wr_en & (reg_address == ADDR_POWER) & (reg_bytecnt == 16'd0);
  assign wr_pulse   = wr_en & (reg_address == ADDR_PULSE);
  assign pulse_go   = wr_pulse & (reg_bytecnt == PULSE_GO_BYTE) & reg_datai[0];

  // Per-channel bytes are matched against the full byte count, so indices at
  // or beyond NUM_IO simply match nothing and the write is dropped.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int k = 0; k < NUM_IO; k++) begin
        mode_q[k] <= IOM_HIGHZ;
      end
      gpio_q      <= '1;
      width_q     <= '0;
      power_req_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_IO; k++) begin
        if (wr_iomode && (reg_bytecnt == 16'(k))) begin
          mode_q[k] <= io_mode_e'(reg_datai[1:0]);
        end
        if (wr_iostate && (reg_bytecnt == 16'(k))) begin
          gpio_q[k] <= reg_datai[0];
        end
      end
      if (wr_pulse && (reg_bytecnt == 16'd0)) width_q[7:0]  <= reg_datai;
      if (wr_pulse && (reg_bytecnt == 16'd1)) width_q[15:8] <= reg_datai;
      if (wr_power) power_req_q <= reg_datai[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Pulse counter: loaded with width on go, active while non-zero, so the pin
  // is low for exactly width cycles. Leaving ON aborts any pulse in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset_i || !drive_allow) begin
      pulse_cnt_q <= '0;
    end else if (pulse_go) begin
      pulse_cnt_q <= width_q;
    end else if (pulse_cnt_q != '0) begin
      pulse_cnt_q <= pulse_cnt_q - 16'd1;
    end
  end

  // Gated with drive_allow so the abort is visible in the same cycle the
  // sequencer leaves ON, before the counter clears on the next edge.
  assign pulse_active = (pulse_cnt_q != '0) & drive_allow;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
    end
  end

  assign io_sync = sync2_q;

  // ---------------------------------------------------------------------------
  // Pad output mux
  // ---------------------------------------------------------------------------
  always_comb begin
    oe_raw  = '0;
    out_raw = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      case (mode_q[k])
        IOM_GPIO: begin
          oe_raw[k]  = 1'b1;
          out_raw[k] = gpio_q[k];
        end
        IOM_ALT: begin
          oe_raw[k]  = alt_oe[k];
          out_raw[k] = alt_out[k];
        end
        IOM_PULSE: begin
          oe_raw[k]  = 1'b1;
          out_raw[k] = pulse_active ? 1'b0 : gpio_q[k];
        end
        default: begin
          oe_raw[k]  = 1'b0;
          out_raw[k] = 1'b0;
        end
      endcase
    end
  end

  // Gating is purely combinational on the sequencer state: no pin can be
  // driven while the target supply is ramping, draining or off.
  assign io_oe  = drive_allow ? oe_raw  : '0;
  assign io_out = drive_allow ? out_raw : '0;

  // ---------------------------------------------------------------------------
  // Register reads
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = 8'h00;
    if (reg_address == ADDR_IOMODE) begin
      for (int k = 0; k < NUM_IO; k++) begin
        if (reg_bytecnt == 16'(k)) rd_data = {6'b0, mode_q[k]};
      end
    end else if (reg_address == ADDR_IOSTATE) begin
      for (int k = 0; k < NUM_IO; k++) begin
        if (reg_bytecnt == 16'(k)) rd_data = {6'b0, sync2_q[k], gpio_q[k]};
      end
    end else if (reg_address == ADDR_POWER) begin
      if (reg_bytecnt == 16'd0) rd_data = {4'b0, pwr_state, pwr_ready, power_req_q};
    end else if (reg_address == ADDR_PULSE) begin
      case (reg_bytecnt)
        16'd0:   rd_data = width_q[7:0];
        16'd1:   rd_data = width_q[15:8];
        16'd2:   rd_data = {7'b0, pulse_active};
        default: rd_data = 8'h00;
      endcase
    end
  end

  // Registered read data; held at 0 whenever no read is active so this block
  // can be OR-combined with the other register-bus slaves.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      reg_datao <= 8'h00;
    end else if (rd_en) begin
      reg_datao <= rd_data;
    end else begin
      reg_datao <= 8'h00;
    end
  end

  // ---------------------------------------------------------------------------
  // Register length query
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_hyplen = 16'd0;
    if (reg_hypaddress == ADDR_IOMODE)       reg_hyplen = IO_LEN;
    else if (reg_hypaddress == ADDR_IOSTATE) reg_hyplen = IO_LEN;
    else if (reg_hypaddress == ADDR_POWER)   reg_hyplen = POWER_LEN;
    else if (reg_hypaddress == ADDR_PULSE)   reg_hyplen = PULSE_LEN;
  end

endmodule

// File: tb/tb_target_io_ctrl.sv
// Purpose: directed self-checking bench for target_io_ctrl (SETTLE_CYC=16, DRAIN_CYC=8).
// Latency: inputs driven and outputs sampled on the falling edge; one scenario task per feature.
// Backpressure: n/a.
module tb_target_io_ctrl;
  import target_io_pkg::*;

  localparam int NUM_IO = 8;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [5:0]        reg_address;
  logic [15:0]       reg_bytecnt;
  logic [7:0]        reg_datai;
  logic [7:0]        reg_datao;
  logic [15:0]       reg_size;
  logic              reg_read;
  logic              reg_write;
  logic              reg_addrvalid;
  logic [5:0]        reg_hypaddress;
  logic [15:0]       reg_hyplen;
  logic [NUM_IO-1:0] io_in;
  logic [NUM_IO-1:0] alt_out;
  logic [NUM_IO-1:0] alt_oe;
  logic [NUM_IO-1:0] io_out;
  logic [NUM_IO-1:0] io_oe;
  logic [NUM_IO-1:0] io_sync;
  logic              target_npower;
  logic              pwr_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  target_io_ctrl #(
    .NUM_IO     (NUM_IO),
    .SETTLE_CYC (16),
    .DRAIN_CYC  (8)
  ) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .reg_datai      (reg_datai),
    .reg_datao      (reg_datao),
    .reg_size       (reg_size),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .reg_hypaddress (reg_hypaddress),
    .reg_hyplen     (reg_hyplen),
    .io_in          (io_in),
    .alt_out        (alt_out),
    .alt_oe         (alt_oe),
    .io_out         (io_out),
    .io_oe          (io_oe),
    .io_sync        (io_sync),
    .target_npower  (target_npower),
    .pwr_ready      (pwr_ready)
  );

  // Called on a falling edge; the write lands on the next rising edge and the
  // task returns on the falling edge right after it.
  task automatic bus_write(input logic [5:0] a, input logic [15:0] b, input logic [7:0] d);
    reg_address   = a;
    reg_bytecnt   = b;
    reg_datai     = d;
    reg_write     = 1'b1;
    reg_addrvalid = 1'b1;
    @(negedge clk);
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  // Called on a falling edge; returns the registered read data one clock later.
  task automatic bus_read(input logic [5:0] a, input logic [15:0] b, output logic [7:0] d);
    reg_address   = a;
    reg_bytecnt   = b;
    reg_read      = 1'b1;
    reg_addrvalid = 1'b1;
    @(negedge clk);
    d             = reg_datao;
    reg_read      = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    checks++; if (target_npower !== 1'b1) begin errors++; $display("FAIL reset_npower: got %b want 1", target_npower); end
    checks++; if (io_oe !== 8'h00) begin errors++; $display("FAIL reset_io_oe: got %h want 00", io_oe); end
    checks++; if (io_out !== 8'h00) begin errors++; $display("FAIL reset_io_out: got %h want 00", io_out); end
    checks++; if (pwr_ready !== 1'b0) begin errors++; $display("FAIL reset_pwr_ready: got %b want 0", pwr_ready); end
    checks++; if (reg_datao !== 8'h00) begin errors++; $display("FAIL reset_datao: got %h want 00", reg_datao); end
    bus_read(ADDR_IOSTATE_DEF, 16'd0, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL reset_iostate0: got %h want 01", d); end
    bus_read(ADDR_IOMODE_DEF, 16'd5, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_iomode5: got %h want 00", d); end
    bus_read(ADDR_POWER_DEF, 16'd0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_power: got %h want 00", d); end
  endtask

  task automatic test_power_up();
    bus_write(ADDR_IOMODE_DEF, 16'd0, 8'h01);
    checks++; if (io_oe !== 8'h00) begin errors++; $display("FAIL off_gpio_oe: got %h want 00", io_oe); end
    bus_write(ADDR_POWER_DEF, 16'd0, 8'h01);
    checks++; if (target_npower !== 1'b1) begin errors++; $display("FAIL pwrup_npower_c0: got %b want 1", target_npower); end
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clk);
      checks++; if (target_npower !== 1'b0) begin errors++; $display("FAIL pwrup_npower c%0d: got %b want 0", cyc, target_npower); end
      checks++; if (pwr_ready !== (cyc == 17)) begin errors++; $display("FAIL pwrup_ready c%0d: got %b want %b", cyc, pwr_ready, cyc == 17); end
      checks++; if (io_oe !== ((cyc == 17) ? 8'h01 : 8'h00)) begin errors++; $display("FAIL pwrup_oe c%0d: got %h", cyc, io_oe); end
    end
  endtask

  task automatic test_gpio();
    logic [7:0] d;
    bus_write(ADDR_IOMODE_DEF, 16'd2, 8'h01);
    bus_write(ADDR_IOSTATE_DEF, 16'd2, 8'h00);
    checks++; if (io_oe !== 8'h05) begin errors++; $display("FAIL gpio_oe: got %h want 05", io_oe); end
    checks++; if (io_out !== 8'h01) begin errors++; $display("FAIL gpio_out: got %h want 01", io_out); end
    io_in = 8'h04;
    repeat (2) @(negedge clk);
    bus_read(ADDR_IOSTATE_DEF, 16'd2, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL gpio_readback2: got %h want 02", d); end
    bus_read(ADDR_POWER_DEF, 16'd0, d);
    checks++; if (d !== 8'h0B) begin errors++; $display("FAIL power_on_read: got %h want 0b", d); end
  endtask

  task automatic test_pulse();
    logic [7:0] d;
    bus_write(ADDR_IOMODE_DEF, 16'd1, 8'h03);
    checks++; if (io_out[1] !== 1'b1 || io_oe[1] !== 1'b1) begin errors++; $display("FAIL pulse_idle: got out=%b oe=%b want 1 1", io_out[1], io_oe[1]); end
    bus_write(ADDR_PULSE_DEF, 16'd0, 8'd5);
    bus_write(ADDR_PULSE_DEF, 16'd1, 8'd0);
    bus_write(ADDR_PULSE_DEF, 16'd2, 8'h01);
    for (int k = 0; k < 6; k++) begin
      checks++; if (io_out[1] !== (k == 5)) begin errors++; $display("FAIL pulse_single c%0d: got %b want %b", k, io_out[1], k == 5); end
      @(negedge clk);
    end
    // Restart: second go on the third cycle of the pulse.
    bus_write(ADDR_PULSE_DEF, 16'd2, 8'h01);
    checks++; if (io_out[1] !== 1'b0) begin errors++; $display("FAIL pulse_restart c0: got %b want 0", io_out[1]); end
    repeat (2) @(negedge clk);
    checks++; if (io_out[1] !== 1'b0) begin errors++; $display("FAIL pulse_restart c2: got %b want 0", io_out[1]); end
    bus_write(ADDR_PULSE_DEF, 16'd2, 8'h01);
    for (int k = 3; k <= 8; k++) begin
      checks++; if (io_out[1] !== (k == 8)) begin errors++; $display("FAIL pulse_restart c%0d: got %b want %b", k, io_out[1], k == 8); end
      @(negedge clk);
    end
    // Zero width produces no pulse.
    bus_write(ADDR_PULSE_DEF, 16'd0, 8'd0);
    bus_write(ADDR_PULSE_DEF, 16'd2, 8'h01);
    checks++; if (io_out[1] !== 1'b1) begin errors++; $display("FAIL pulse_zero_width: got %b want 1", io_out[1]); end
    bus_read(ADDR_PULSE_DEF, 16'd2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL pulse_zero_active: got %h want 00", d); end
    bus_write(ADDR_PULSE_DEF, 16'd0, 8'd5);
    bus_read(ADDR_PULSE_DEF, 16'd0, d);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL pulse_width_read: got %h want 05", d); end
  endtask

  task automatic test_alt();
    logic [7:0] d;
    alt_oe  = 8'h00;
    alt_out = 8'h00;
    bus_write(ADDR_IOMODE_DEF, 16'd3, 8'h02);
    checks++; if (io_oe[3] !== 1'b0) begin errors++; $display("FAIL alt_oe_off: got %b want 0", io_oe[3]); end
    alt_oe  = 8'h08;
    alt_out = 8'h08;
    #1;
    checks++; if (io_oe[3] !== 1'b1 || io_out[3] !== 1'b1) begin errors++; $display("FAIL alt_follow_hi: got oe=%b out=%b want 1 1", io_oe[3], io_out[3]); end
    alt_out = 8'h00;
    #1;
    checks++; if (io_out[3] !== 1'b0) begin errors++; $display("FAIL alt_follow_lo: got %b want 0", io_out[3]); end
    alt_out = 8'h08;
    @(negedge clk);
    bus_read(ADDR_IOMODE_DEF, 16'd3, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL alt_mode_read: got %h want 02", d); end
  endtask

  task automatic test_drain();
    logic [7:0] d;
    int cyc;
    bus_write(ADDR_PULSE_DEF, 16'd2, 8'h01);
    checks++; if (io_out[1] !== 1'b0) begin errors++; $display("FAIL drain_pulse_start: got %b want 0", io_out[1]); end
    bus_write(ADDR_POWER_DEF, 16'd0, 8'h00);
    checks++; if (io_oe !== 8'h0F) begin errors++; $display("FAIL drain_c0_oe: got %h want 0f", io_oe); end
    @(negedge clk);
    checks++; if (io_oe !== 8'h00) begin errors++; $display("FAIL drain_c1_oe: got %h want 00", io_oe); end
    checks++; if (io_out !== 8'h00) begin errors++; $display("FAIL drain_c1_out: got %h want 00", io_out); end
    checks++; if (pwr_ready !== 1'b0 || target_npower !== 1'b0) begin errors++; $display("FAIL drain_c1_pwr: got ready=%b npower=%b want 0 0", pwr_ready, target_npower); end
    bus_read(ADDR_PULSE_DEF, 16'd2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL drain_pulse_abort: got %h want 00", d); end
    cyc = 2;
    while (cyc < 9) begin
      @(negedge clk);
      cyc++;
      checks++; if (target_npower !== (cyc == 9)) begin errors++; $display("FAIL drain_npower c%0d: got %b want %b", cyc, target_npower, cyc == 9); end
      checks++; if (io_oe !== 8'h00) begin errors++; $display("FAIL drain_oe c%0d: got %h want 00", cyc, io_oe); end
    end
    bus_read(ADDR_POWER_DEF, 16'd0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL drain_power_read: got %h want 00", d); end
    bus_read(ADDR_IOMODE_DEF, 16'd1, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL mode_retained: got %h want 03", d); end
  endtask

  task automatic test_hyplen();
    reg_hypaddress = ADDR_IOMODE_DEF;
    #1;
    checks++; if (reg_hyplen !== 16'd8) begin errors++; $display("FAIL hyplen_iomode: got %0d want 8", reg_hyplen); end
    reg_hypaddress = ADDR_IOSTATE_DEF;
    #1;
    checks++; if (reg_hyplen !== 16'd8) begin errors++; $display("FAIL hyplen_iostate: got %0d want 8", reg_hyplen); end
    reg_hypaddress = ADDR_POWER_DEF;
    #1;
    checks++; if (reg_hyplen !== 16'd1) begin errors++; $display("FAIL hyplen_power: got %0d want 1", reg_hyplen); end
    reg_hypaddress = ADDR_PULSE_DEF;
    #1;
    checks++; if (reg_hyplen !== 16'd3) begin errors++; $display("FAIL hyplen_pulse: got %0d want 3", reg_hyplen); end
    reg_hypaddress = 6'd10;
    #1;
    checks++; if (reg_hyplen !== 16'd0) begin errors++; $display("FAIL hyplen_unowned: got %0d want 0", reg_hyplen); end
    @(negedge clk);
  endtask

  task automatic test_ignored_write();
    logic [7:0] d;
    bus_write(ADDR_IOMODE_DEF, 16'd8, 8'h03);
    bus_write(ADDR_IOSTATE_DEF, 16'd8, 8'h00);
    bus_read(ADDR_IOMODE_DEF, 16'd0, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL ignored_mode0: got %h want 01", d); end
    bus_read(ADDR_IOSTATE_DEF, 16'd0, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL ignored_gpio0: got %h want 01", d); end
    bus_read(ADDR_IOMODE_DEF, 16'd8, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL oob_read: got %h want 00", d); end
    @(negedge clk);
    checks++; if (reg_datao !== 8'h00) begin errors++; $display("FAIL idle_datao: got %h want 00", reg_datao); end
  endtask

  initial begin
    reset_i        = 1'b1;
    reg_address    = '0;
    reg_bytecnt    = '0;
    reg_datai      = '0;
    reg_size       = 16'd1;
    reg_read       = 1'b0;
    reg_write      = 1'b0;
    reg_addrvalid  = 1'b0;
    reg_hypaddress = '0;
    io_in          = '0;
    alt_out        = '0;
    alt_oe         = '0;
    @(negedge clk);
    test_reset();
    test_power_up();
    test_gpio();
    test_pulse();
    test_alt();
    test_drain();
    test_hyplen();
    test_ignored_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
